// File: rtl/usb_device_line_receiver.sv
// USB device-side line receiver: SYNC detect, NRZI decode, bit unstuffing, byte assembly, EOP check.
// Optional first-byte PID check enabled by defining USB_RX_PID_CHECK_EN.
module usb_device_line_receiver #(
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] IDLE_state,
  input  logic [1:0] J_state,
  input  logic [1:0] K_state,
  input  logic [1:0] usb_signals,
  output logic [7:0] rx_byte,
  output logic       rx_byte_val,
  output logic       rx_last,
  output logic       rx_active,
  output logic       rx_error,
  output logic       bus_reset
);

  localparam int unsigned RstW = $clog2(RESET_CYCLES + 1);
  localparam logic [RstW-1:0] RstMax = RstW'(RESET_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StEop,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      prev_q, prev_d;
  logic [2:0]      zero_cnt_q, zero_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      ones_cnt_q, ones_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [1:0]      se0_cnt_q, se0_cnt_d;
  logic [2:0]      j_cnt_q, j_cnt_d;
  logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_byte_val_q, rx_byte_val_d;
  logic            rx_last_q, rx_last_d;
  logic            rx_active_q, rx_active_d;
  logic            rx_error_q, rx_error_d;
  logic            bus_reset_q, bus_reset_d;
`ifdef USB_RX_PID_CHECK_EN
  logic            first_q, first_d;
`endif

  logic       is_se0, is_se1, is_j, is_k, is_idle, nrzi_bit, fail;
  logic [7:0] byte_done;

  assign is_se0    = (usb_signals == 2'b00);
  assign is_se1    = (usb_signals == 2'b11);
  assign is_j      = (usb_signals == J_state);
  assign is_k      = (usb_signals == K_state);
  assign is_idle   = (usb_signals == IDLE_state);
  assign nrzi_bit  = (usb_signals == prev_q);
  assign byte_done = {nrzi_bit, shift_q[7:1]};

  always_comb begin
    state_d       = state_q;
    prev_d        = usb_signals;
    zero_cnt_d    = zero_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    ones_cnt_d    = ones_cnt_q;
    shift_d       = shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    se0_cnt_d     = se0_cnt_q;
    j_cnt_d       = j_cnt_q;
    rx_byte_d     = rx_byte_q;
    rx_byte_val_d = 1'b0;
    rx_last_d     = 1'b0;
    rx_active_d   = rx_active_q;
    rx_error_d    = 1'b0;
    fail          = 1'b0;
`ifdef USB_RX_PID_CHECK_EN
    first_d       = first_q;
`endif

    if (is_se0) begin
      rst_cnt_d = (rst_cnt_q == RstMax) ? RstMax : rst_cnt_q + 1'b1;
    end else begin
      rst_cnt_d = '0;
    end
    bus_reset_d = (rst_cnt_d == RstMax);

    unique case (state_q)
      StIdle: begin
        if (prev_q == J_state && is_k) begin
          state_d    = StSync;
          zero_cnt_d = '0;
        end
      end
      StSync: begin
        if (is_se1) begin
          fail    = 1'b1;
          state_d = StWaitIdle;
        end else if (is_se0) begin
          state_d = StIdle;
        end else if (!nrzi_bit) begin
          if (zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
        end else if (zero_cnt_q >= 3'd5) begin
          state_d     = StData;
          rx_active_d = 1'b1;
          bit_cnt_d   = '0;
          ones_cnt_d  = 3'd1;
          hold_full_d = 1'b0;
`ifdef USB_RX_PID_CHECK_EN
          first_d     = 1'b1;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (is_se1) begin
          fail    = 1'b1;
          state_d = StWaitIdle;
        end else if (is_se0) begin
          // EOP wins over a pending stuff bit.
          state_d   = StEop;
          se0_cnt_d = 2'd1;
        end else if (ones_cnt_q == 3'd6) begin
          if (nrzi_bit) begin
            fail    = 1'b1;
            state_d = StWaitIdle;
          end else begin
            ones_cnt_d = '0;
          end
        end else begin
          shift_d    = byte_done;
          ones_cnt_d = nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
`ifdef USB_RX_PID_CHECK_EN
            first_d   = 1'b0;
            if (first_q && (byte_done[3:0] != ~byte_done[7:4])) begin
              fail    = 1'b1;
              state_d = StWaitIdle;
            end else
`endif
            begin
              // One-deep hold so the last byte can be tagged once EOP is seen.
              if (hold_full_q) begin
                rx_byte_val_d = 1'b1;
                rx_byte_d     = hold_q;
              end
              hold_d      = byte_done;
              hold_full_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StEop: begin
        if (is_se1 || is_k) begin
          fail    = 1'b1;
          state_d = StWaitIdle;
        end else if (is_se0) begin
          if (se0_cnt_q == 2'd2) begin
            fail    = 1'b1;
            state_d = StWaitIdle;
          end else begin
            se0_cnt_d = 2'd2;
          end
        end else if (is_j) begin
          state_d = StIdle;
          if (bit_cnt_q == 3'd0 && hold_full_q) begin
            rx_byte_val_d = 1'b1;
            rx_last_d     = 1'b1;
            rx_byte_d     = hold_q;
            rx_active_d   = 1'b0;
            hold_full_d   = 1'b0;
          end else begin
            fail = 1'b1;
          end
        end
      end
      StWaitIdle: begin
        if (is_idle) begin
          if (prev_q == 2'b00 || j_cnt_q == 3'd6) begin
            state_d = StIdle;
            j_cnt_d = '0;
          end else begin
            j_cnt_d = j_cnt_q + 3'd1;
          end
        end else begin
          j_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus_reset_d && !bus_reset_q && (state_d inside {StSync, StData, StEop})) begin
      fail    = 1'b1;
      state_d = StWaitIdle;
    end

    if (fail) begin
      rx_error_d    = 1'b1;
      rx_active_d   = 1'b0;
      hold_full_d   = 1'b0;
      rx_byte_val_d = 1'b0;
      rx_last_d     = 1'b0;
      j_cnt_d       = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      prev_q        <= 2'b00;
      zero_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      ones_cnt_q    <= '0;
      shift_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      se0_cnt_q     <= '0;
      j_cnt_q       <= '0;
      rst_cnt_q     <= '0;
      rx_byte_q     <= '0;
      rx_byte_val_q <= 1'b0;
      rx_last_q     <= 1'b0;
      rx_active_q   <= 1'b0;
      rx_error_q    <= 1'b0;
      bus_reset_q   <= 1'b0;
`ifdef USB_RX_PID_CHECK_EN
      first_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      zero_cnt_q    <= zero_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      ones_cnt_q    <= ones_cnt_d;
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      se0_cnt_q     <= se0_cnt_d;
      j_cnt_q       <= j_cnt_d;
      rst_cnt_q     <= rst_cnt_d;
      rx_byte_q     <= rx_byte_d;
      rx_byte_val_q <= rx_byte_val_d;
      rx_last_q     <= rx_last_d;
      rx_active_q   <= rx_active_d;
      rx_error_q    <= rx_error_d;
      bus_reset_q   <= bus_reset_d;
`ifdef USB_RX_PID_CHECK_EN
      first_q       <= first_d;
`endif
    end
  end

  assign rx_byte     = rx_byte_q;
  assign rx_byte_val = rx_byte_val_q;
  assign rx_last     = rx_last_q;
  assign rx_active   = rx_active_q;
  assign rx_error    = rx_error_q;
  assign bus_reset   = bus_reset_q;

endmodule

// File: tb/tb_usb_device_line_receiver.sv
// Scoreboard bench for usb_device_line_receiver: NRZI/stuffing encoder drives packets, a monitor
// compares every rx_byte_val / rx_error pulse against queued expectations.
module tb_usb_device_line_receiver;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] usb;
  logic [7:0] rx_byte;
  logic       rx_byte_val, rx_last, rx_active, rx_error, bus_reset;

  usb_device_line_receiver #(.RESET_CYCLES(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .IDLE_state (J),
    .J_state    (J),
    .K_state    (K),
    .usb_signals(usb),
    .rx_byte    (rx_byte),
    .rx_byte_val(rx_byte_val),
    .rx_last    (rx_last),
    .rx_active  (rx_active),
    .rx_error   (rx_error),
    .bus_reset  (bus_reset)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       is_err;
    logic [7:0] b;
    logic       last;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] lvl;
  int         ones;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic last);
    exp_q.push_back('{is_err: 1'b0, b: b, last: last});
  endtask

  task automatic expect_err();
    exp_q.push_back('{is_err: 1'b1, b: 8'h00, last: 1'b0});
  endtask

  // Apply a line sample for one bit time; returns just after the sampling edge.
  task automatic put(input logic [1:0] v);
    usb = v;
    @(posedge clock);
    #1;
  endtask

  task automatic send_raw_bit(input logic b);
    if (!b) lvl = (lvl == J) ? K : J;
    put(lvl);
  endtask

  task automatic send_bit(input logic b);
    send_raw_bit(b);
    if (b) begin
      ones++;
      if (ones == 6) begin
        send_raw_bit(1'b0);
        ones = 0;
      end
    end else begin
      ones = 0;
    end
  endtask

  task automatic send_sync();
    lvl = J;
    for (int i = 0; i < 7; i++) send_raw_bit(1'b0);
    send_raw_bit(1'b1);
    ones = 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_eop();
    put(SE0);
    put(SE0);
    put(J);
    lvl = J;
  endtask

  task automatic idle(input int n);
    lvl = J;
    repeat (n) put(J);
  endtask

  always @(negedge clock) begin
    if (rx_byte_val || rx_error) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: val=%0b err=%0b byte=0x%0h last=%0b, none expected",
                 rx_byte_val, rx_error, rx_byte, rx_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_err) begin
          if (!rx_error || rx_byte_val) begin
            errors++;
            $display("FAIL event_kind: got val=%0b err=%0b, expected rx_error", rx_byte_val,
                     rx_error);
          end
        end else if (rx_error || {rx_byte, rx_last} !== {mon_e.b, mon_e.last}) begin
          errors++;
          $display("FAIL rx_byte: got err=%0b byte=0x%0h last=%0b expected byte=0x%0h last=%0b",
                   rx_error, rx_byte, rx_last, mon_e.b, mon_e.last);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    usb   = J;
    lvl   = J;
    ones  = 0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {18'd0, rx_byte, rx_byte_val, rx_last, rx_active, rx_error, bus_reset},
          32'd0);
    reset = 1'b0;
    idle(4);

    // Single-byte packet with timing checks on rx_active and the final pulse.
    expect_byte(8'hD2, 1'b1);
    send_sync();
    check("active_rise", {31'd0, rx_active}, 32'd1);
    send_byte(8'hD2);
    send_eop();
    check("last_timing", {30'd0, rx_byte_val, rx_last}, 32'd3);
    check("active_fall", {31'd0, rx_active}, 32'd0);
    idle(3);

    // Multi-byte packet including a stuffed bit inside 0xFF.
    expect_byte(8'hC3, 1'b0);
    expect_byte(8'hFF, 1'b0);
    expect_byte(8'h00, 1'b1);
    send_sync();
    send_byte(8'hC3);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_eop();
    idle(3);

    // Stuffing violation, recovery via SE0 -> J, then a good packet.
    expect_err();
    send_sync();
    send_byte(8'hC3);
    repeat (7) put(lvl);
    put(SE0);
    put(J);
    idle(3);
    expect_byte(8'h4B, 1'b1);
    send_sync();
    send_byte(8'h4B);
    send_eop();
    idle(3);

    // PID 0xD3 fails the optional check.
`ifdef USB_RX_PID_CHECK_EN
    expect_err();
`else
    expect_byte(8'hD3, 1'b1);
`endif
    send_sync();
    send_byte(8'hD3);
    send_eop();
    idle(3);

    // EOP with no byte received.
    expect_err();
    send_sync();
    send_eop();
    idle(3);

    // EOP with a partial byte.
    expect_err();
    send_sync();
    send_byte(8'h2D);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_eop();
    idle(3);

    // Three SE0 samples before J.
    expect_err();
    send_sync();
    send_byte(8'hA5);
    repeat (3) put(SE0);
    put(J);
    idle(3);

    // Bus reset detection.
    for (int i = 1; i <= 20; i++) begin
      put(SE0);
      if (i == 15) check("bus_reset_before", {31'd0, bus_reset}, 32'd0);
      if (i == 16) check("bus_reset_rise", {31'd0, bus_reset}, 32'd1);
    end
    put(J);
    check("bus_reset_fall", {31'd0, bus_reset}, 32'd0);
    idle(3);

    // Reset after 12 data bits drops the packet silently.
    send_sync();
    send_byte(8'hA5);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    put(J);
    check("midpkt_reset_outputs",
          {18'd0, rx_byte, rx_byte_val, rx_last, rx_active, rx_error, bus_reset}, 32'd0);
    reset = 1'b0;
    idle(4);
    expect_byte(8'h69, 1'b1);
    send_sync();
    send_byte(8'h69);
    send_eop();
    idle(20);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_device_line_receiver.md
# usb_device_line_receiver

Device-end receive path for the USB link: samples the `usb_signals` D+/D- pair once per `clock` (bit clock), detects SYNC, NRZI-decodes, removes stuffed bits, assembles LSB-first bytes and validates EOP. It is the counterpart of the host-side line driver. It delivers whole packets to the device SIPO/FIFO as a byte stream tagged with `rx_last`, and flags line errors and bus reset.

## Interface
Parameters:
- `RESET_CYCLES`, 16, consecutive SE0 samples that declare bus reset. Minimum 4.

Ports:
- `clock`  in  1  bit-rate clock. All state changes on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `IDLE_state`  in  2  line idle encoding. Equals `J_state` for the configured speed.
- `J_state`  in  2  J encoding of {D+, D-}.
- `K_state`  in  2  K encoding of {D+, D-}.
- `usb_signals`  in  2  {D+, D-}, sampled only.
- `rx_byte`  out  8  received byte, LSB = first bit on the wire.
- `rx_byte_val`  out  1  one-cycle pulse; `rx_byte` is valid in that cycle.
- `rx_last`  out  1  high with `rx_byte_val` on the final byte of a good packet.
- `rx_active`  out  1  high from SYNC completion until packet end or error.
- `rx_error`  out  1  one-cycle pulse on any line error; the packet is dropped.
- `bus_reset`  out  1  level; high while SE0 persists for ≥ `RESET_CYCLES` samples.

## Operation
- All outputs reset to 0 and the state machine resets to IDLE. A reset mid-packet drops the packet silently: no `rx_error`, no `rx_last`.
- NRZI decoding: bit = 1 if the current sample equals the previous sample (J/K), otherwise 0.
- States:
  - IDLE: on a K sample following a J sample, go to SYNC with zero_cnt = 0.
  - SYNC: each decoded 0 increments zero_cnt.
    - Decoded 1 with zero_cnt ≥ 5: go to DATA, assert `rx_active`, set bit_cnt = 0 and ones_cnt = 1.
    - Decoded 1 with zero_cnt < 5: return to IDLE with no error.
    - SE0: return to IDLE.
  - DATA:
    - Each decoded bit shifts into the shift register at bit 7, shifting right. ones_cnt counts consecutive 1s.
    - When ones_cnt == 6, the next bit must be 0 and is discarded. If it is 1, pulse `rx_error` and go to WAIT_IDLE.
    - At bit_cnt == 8, the byte moves into a one-deep hold register. If the hold register was already full, its previous content is emitted first with `rx_byte_val`.
    - SE0 goes to EOP. EOP takes precedence over a pending stuff bit.
  - EOP:
    - Requires 1–2 SE0 samples followed by a J.
    - On J with bit_cnt == 0 and the hold register full: emit the held byte with `rx_byte_val` = `rx_last` = 1, drop `rx_active`, and go to IDLE.
    - Any other ending is an error: a third SE0 before J, a K, bit_cnt ≠ 0, or no byte received. Each pulses `rx_error`, drops `rx_active`, and discards the held byte. A third SE0 goes to WAIT_IDLE, which then tracks bus reset.
  - WAIT_IDLE: go to IDLE after SE0 → J, or after 7 consecutive J samples.
- `bus_reset` is independent of state. An SE0 counter saturates at `RESET_CYCLES`. `bus_reset` = (counter == `RESET_CYCLES`) and clears on the first non-SE0 sample. An active packet aborts with `rx_error`.
- An SE1 sample in SYNC, DATA or EOP pulses `rx_error` and goes to WAIT_IDLE.

## Timing
- Wire bit k is sampled at edge t. A byte completes at the edge sampling its 8th unstuffed bit.
- Non-final byte: `rx_byte_val` is high in the cycle after the edge that completes the following byte.
- Final byte: `rx_byte_val` and `rx_last` are high in the cycle after the edge sampling the EOP J.
- `rx_error` is high in the cycle after the offending sample.
- `rx_active` rises in the cycle after the SYNC-terminating sample and falls together with the `rx_last` or `rx_error` pulse.
- Minimum gap between `rx_byte_val` pulses is 8 cycles. No backpressure: the consumer must accept every pulse.

## Configuration
- `USB_RX_PID_CHECK_EN` defined:
  - The first byte must satisfy PID[3:0] == ~PID[7:4].
  - On mismatch, pulse `rx_error` when the byte completes, emit nothing, and go to WAIT_IDLE.
- Not defined: no PID check; the first byte passes through like any other byte.

## Test plan
- J idle, SYNC (KJKJKJKK), PID 0xD2, SE0 SE0 J → one `rx_byte_val`: `rx_byte` = 0xD2 with `rx_last` = 1, and `rx_error` stays 0.
- SYNC, 0xC3, 0xFF, 0x00, EOP → three pulses of 0xC3, 0xFF, 0x00. The stuffed 0 after six 1s in 0xFF is absorbed, and `rx_last` is asserted only on 0x00.
- SYNC, PID 0xC3, then seven non-toggling samples → `rx_error` pulse and no `rx_byte_val`. After SE0 → J, a following good packet is received normally.
- With `USB_RX_PID_CHECK_EN`: SYNC, 0xD3, EOP → `rx_error` pulse and no `rx_byte_val`. Without the macro: 0xD3 is delivered with `rx_last`.
- SE0 held for 20 cycles → `bus_reset` rises in the cycle after the 16th SE0 sample and falls in the cycle after the first J sample.
- `reset` asserted for 1 cycle after 12 data bits of a packet → all outputs 0. No `rx_error` or `rx_byte_val` occurs for that packet, and the next packet decodes correctly.
